mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared
// single-port memory side. The arbiter uses the slave view; the
// requesters/memory environment use the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // shared memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // pipeline freeze
    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction
// fetch port and a data (lw/sw) port. Arbitration is combinational,
// reads return after exactly one cycle.
// Default build: data wins contention, a starvation counter forces a
// fetch win after STARVE_MAX consecutive denied fetch cycles.
// Optional macro MEM_ARB_RR_EN: round-robin on contention instead
// (fetch wins the first contention after reset), no starvation counter.
module mem_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clka,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              if_gnt;
    logic              d_gnt;
    logic              if_wins;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] if_rdata_hold;
    logic [DATA_W-1:0] d_rdata_hold;
    logic              if_rvalid;
    logic              d_rvalid;

`ifdef MEM_ARB_RR_EN
    // 1 when the data port held the most recent grant; starts at 1 so
    // fetch takes the first contention after reset.
    logic last_d;

    // Remember which port was granted last.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            last_d <= 1'b1;
        end else if (if_gnt) begin
            last_d <= 1'b0;
        end else if (d_gnt) begin
            last_d <= 1'b1;
        end
    end

    assign if_wins = last_d;
`else
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // Count consecutive cycles fetch is kept waiting, saturating at the limit.
    always_ff @(posedge clka) begin
        if (!rst_n || !bus.if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign if_wins = (starve_cnt == STARVE_LIM);
`endif

    // Pick at most one requesting port; nothing is granted while in reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (bus.if_req && bus.d_req) begin
                if (if_wins) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end else if (bus.d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Steer the winner onto the memory and choose which read returns next.
    always_comb begin
        state_next = IDLE;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (if_gnt) begin
            mem_en     = 1'b1;
            mem_addr   = bus.if_addr;
            state_next = RD_IF;
        end else if (d_gnt) begin
            mem_en     = 1'b1;
            mem_we     = bus.d_we;
            mem_addr   = bus.d_addr;
            mem_wdata  = bus.d_wdata;
            state_next = bus.d_we ? IDLE : RD_D;
        end
    end

    // Track which port owns the read data arriving next cycle.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Keep the last delivered word per port so rdata holds between reads.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            if_rdata_hold <= '0;
            d_rdata_hold  <= '0;
        end else begin
            if (state == RD_IF) begin
                if_rdata_hold <= bus.mem_rdata;
            end
            if (state == RD_D) begin
                d_rdata_hold <= bus.mem_rdata;
            end
        end
    end

    // A read in flight when reset asserts is dropped, never reported valid.
    assign if_rvalid = rst_n && (state == RD_IF);
    assign d_rvalid  = rst_n && (state == RD_D);

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : if_rdata_hold;
    assign bus.d_rdata   = d_rvalid  ? bus.mem_rdata : d_rdata_hold;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.stall     = bus.if_req && !if_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of per-cycle stimulus with expected
// grants, plus a read-data scoreboard fed from a shadow memory model.
module tb_mem_arbiter;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;
    localparam int DEPTH      = 1 << ADDR_W;

    typedef struct {
        logic              if_req;
        logic [ADDR_W-1:0] if_addr;
        logic              d_req;
        logic              d_we;
        logic [ADDR_W-1:0] d_addr;
        logic [DATA_W-1:0] d_wdata;
        logic              exp_if_gnt;
        logic              exp_d_gnt;
        logic              exp_mem_we;
        logic              exp_stall;
    } vec_t;

    typedef struct {
        logic              is_if;
        logic              is_d;
        logic [DATA_W-1:0] data;
    } sb_t;

    logic clka  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clka = ~clka;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clka (clka),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic              preloaded = 1'b0;
    sb_t               sb [$];
    vec_t              rows [$];
    logic [DATA_W-1:0] last_if;
    logic [DATA_W-1:0] last_d;

    function automatic logic [DATA_W-1:0] init_val(int i);
        if (i == 5) return 32'h1234_5678;
        return 32'hC0DE_0000 | DATA_W'(i);
    endfunction

    // Single-port synchronous memory behind the arbiter.
    always @(posedge clka) begin
        if (!preloaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            preloaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic ir, logic [ADDR_W-1:0] ia, logic dr, logic dw,
                                logic [ADDR_W-1:0] da, logic [DATA_W-1:0] dd,
                                logic eig, logic edg, logic ew, logic es);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd;
        v.exp_if_gnt = eig; v.exp_d_gnt = edg; v.exp_mem_we = ew; v.exp_stall = es;
        return v;
    endfunction

    // Drive one cycle, check last cycle's read return and this cycle's grant.
    task automatic apply(input vec_t v, input string tag);
        sb_t e;
        sb_t n;
        @(negedge clka);
        bus.if_req  = v.if_req;
        bus.if_addr = v.if_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=0 required=1", tag);
        end else begin
            e = sb.pop_front();
            chk1({tag, " if_rvalid"}, bus.if_rvalid, e.is_if);
            chk1({tag, " d_rvalid"}, bus.d_rvalid, e.is_d);
            if (e.is_if) last_if = e.data;
            if (e.is_d)  last_d  = e.data;
            chkw({tag, " if_rdata"}, bus.if_rdata, last_if);
            chkw({tag, " d_rdata"}, bus.d_rdata, last_d);
        end
        chk1({tag, " if_gnt"}, bus.if_gnt, v.exp_if_gnt);
        chk1({tag, " d_gnt"}, bus.d_gnt, v.exp_d_gnt);
        chk1({tag, " mem_en"}, bus.mem_en, v.exp_if_gnt | v.exp_d_gnt);
        chk1({tag, " mem_we"}, bus.mem_we, v.exp_mem_we);
        chk1({tag, " stall"}, bus.stall, v.exp_stall);
        if (v.exp_if_gnt)
            chkw({tag, " mem_addr"}, DATA_W'(bus.mem_addr), DATA_W'(v.if_addr));
        if (v.exp_d_gnt)
            chkw({tag, " mem_addr"}, DATA_W'(bus.mem_addr), DATA_W'(v.d_addr));
        if (v.exp_d_gnt && v.d_we)
            chkw({tag, " mem_wdata"}, bus.mem_wdata, v.d_wdata);
        n.is_if = v.exp_if_gnt;
        n.is_d  = v.exp_d_gnt && !v.d_we;
        n.data  = v.exp_if_gnt ? shadow[v.if_addr] : shadow[v.d_addr];
        if (v.exp_d_gnt && v.d_we) shadow[v.d_addr] = v.d_wdata;
        sb.push_back(n);
    endtask

    // Hold reset for two edges with both ports requesting, then release idle.
    task automatic reset_seq(input string tag);
        sb_t none;
        @(negedge clka);
        rst_n = 1'b0;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        #1;
        chk1({tag, " if_gnt"}, bus.if_gnt, 1'b0);
        chk1({tag, " d_gnt"}, bus.d_gnt, 1'b0);
        chk1({tag, " mem_en"}, bus.mem_en, 1'b0);
        @(negedge clka);
        #1;
        chk1({tag, " if_rvalid"}, bus.if_rvalid, 1'b0);
        chk1({tag, " d_rvalid"}, bus.d_rvalid, 1'b0);
        chkw({tag, " if_rdata"}, bus.if_rdata, '0);
        chkw({tag, " d_rdata"}, bus.d_rdata, '0);
        @(negedge clka);
        rst_n = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        sb.delete();
        none.is_if = 1'b0; none.is_d = 1'b0; none.data = '0;
        sb.push_back(none);
        last_if = '0;
        last_d  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
        last_if = '0;
        last_d  = '0;

        // fetch alone, write-then-fetch, single data read
        rows.push_back(mk(1'b1, 7'd5,  1'b0, 1'b0, 7'd0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 7'd0,  1'b0, 1'b0, 7'd0,  32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 7'd0,  1'b1, 1'b1, 7'd15, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0));
        rows.push_back(mk(1'b1, 7'd15, 1'b0, 1'b0, 7'd0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 7'd0,  1'b1, 1'b0, 7'd15, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifndef MEM_ARB_RR_EN
        // contention: D,D,D,IF then D,D, counter cleared by if_req=0, then D,D,D(write),IF
        rows.push_back(mk(1'b1, 7'd20, 1'b1, 1'b0, 7'd21, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd20, 1'b1, 1'b0, 7'd22, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd20, 1'b1, 1'b0, 7'd23, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd20, 1'b1, 1'b0, 7'd24, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b1, 7'd21, 1'b1, 1'b0, 7'd24, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd21, 1'b1, 1'b0, 7'd25, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b0, 7'd0,  1'b1, 1'b0, 7'd26, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk(1'b1, 7'd21, 1'b1, 1'b0, 7'd27, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd21, 1'b1, 1'b0, 7'd28, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd21, 1'b1, 1'b1, 7'd29, 32'h7, 1'b0, 1'b1, 1'b1, 1'b1));
        rows.push_back(mk(1'b1, 7'd21, 1'b1, 1'b0, 7'd29, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
`else
        // round-robin contention (data held the last grant), then single ports
        rows.push_back(mk(1'b1, 7'd40, 1'b1, 1'b0, 7'd41, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b1, 7'd42, 1'b1, 1'b0, 7'd41, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd42, 1'b1, 1'b0, 7'd43, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b1, 7'd44, 1'b1, 1'b0, 7'd43, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        rows.push_back(mk(1'b1, 7'd44, 1'b0, 1'b0, 7'd0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b1, 7'd45, 1'b0, 1'b0, 7'd0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 7'd0,  1'b1, 1'b0, 7'd46, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 7'd0,  1'b1, 1'b0, 7'd47, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk(1'b1, 7'd48, 1'b1, 1'b0, 7'd49, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
        // top address: fetch, write, fetch back
        rows.push_back(mk(1'b1, 7'd127, 1'b0, 1'b0, 7'd0,   32'h0,         1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 7'd0,   1'b1, 1'b1, 7'd127, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0));
        rows.push_back(mk(1'b1, 7'd127, 1'b0, 1'b0, 7'd0,   32'h0,         1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, 7'd0,   1'b0, 1'b0, 7'd0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b0));

        reset_seq("init_reset");
        foreach (rows[i]) apply(rows[i], $sformatf("row%0d", i));

        // data read granted, reset asserted before its data returns
`ifndef MEM_ARB_RR_EN
        apply(mk(1'b1, 7'd40, 1'b1, 1'b0, 7'd41, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "pre_rst0");
        apply(mk(1'b1, 7'd40, 1'b1, 1'b0, 7'd42, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "pre_rst1");
        apply(mk(1'b1, 7'd40, 1'b1, 1'b0, 7'd43, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "pre_rst2");
`else
        apply(mk(1'b0, 7'd0, 1'b1, 1'b0, 7'd43, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0), "pre_rst2");
`endif
        @(posedge clka);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_front());
        #1;
        chk1("squash d_rvalid", bus.d_rvalid, 1'b0);
        chk1("squash d_gnt", bus.d_gnt, 1'b0);
        chk1("squash if_gnt", bus.if_gnt, 1'b0);
        chk1("squash mem_en", bus.mem_en, 1'b0);
        reset_seq("mid_reset");

        // after reset the arbitration history starts over
`ifndef MEM_ARB_RR_EN
        apply(mk(1'b1, 7'd50, 1'b1, 1'b0, 7'd51, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "post_rst0");
        apply(mk(1'b1, 7'd50, 1'b1, 1'b0, 7'd52, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "post_rst1");
        apply(mk(1'b1, 7'd50, 1'b1, 1'b0, 7'd53, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "post_rst2");
        apply(mk(1'b1, 7'd50, 1'b1, 1'b0, 7'd54, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0), "post_rst3");
`else
        apply(mk(1'b1, 7'd50, 1'b1, 1'b0, 7'd51, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0), "post_rst0");
        apply(mk(1'b1, 7'd52, 1'b1, 1'b0, 7'd51, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "post_rst1");
        apply(mk(1'b1, 7'd52, 1'b1, 1'b0, 7'd53, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0), "post_rst2");
        apply(mk(1'b1, 7'd54, 1'b1, 1'b0, 7'd53, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1), "post_rst3");
`endif
        apply(mk(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), "post_rst4");
        apply(mk(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), "post_rst5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
